io_bus_sequencer: RTL and testbench

- Multi-cycle sequencer between the single-cycle core's IO strobes (IORead/IOWrite, raised for addresses 0xFFFFF800–0xFFFFFBFF) and up to four slow peripherals (switches, LEDs, seven-segment, UART).
- Decodes the device from the address and drives a one-hot select/ack handshake.
- Stalls the core until the access completes or times out, and returns read data through a register.

---
 rtl/io_bus_sequencer_if.sv | 36 +++
 rtl/io_bus_sequencer.sv | 116 +++++++++++
 tb/tb_io_bus_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// io_bus_sequencer_if
// Purpose : bundles the core-side IO strobes and the peripheral-side
//           select/ack bus of the IO sequencer into one connection.
// Signals : io_read/io_write/addr/wdata  core strobes and store data
//           rdata/stall/err              results returned to the core
//           dev_sel/dev_we/dev_addr/dev_wdata  one-hot select bus to devices
//           dev_rdata/dev_ack            per-device read data and completion
// Modports: master - the sequencer (drives stall/rdata and the device bus)
//           slave  - the environment (core strobes plus peripherals)
// ---------------------------------------------------------------------------
interface io_bus_sequencer_if;
  logic         io_read;
  logic         io_write;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         stall;
  logic         err;
  logic [3:0]   dev_sel;
  logic         dev_we;
  logic [7:0]   dev_addr;
  logic [31:0]  dev_wdata;
  logic [127:0] dev_rdata;
  logic [3:0]   dev_ack;

  modport master (
    input  io_read, io_write, addr, wdata, dev_rdata, dev_ack,
    output rdata, stall, err, dev_sel, dev_we, dev_addr, dev_wdata
  );

  modport slave (
    output io_read, io_write, addr, wdata, dev_rdata, dev_ack,
    input  rdata, stall, err, dev_sel, dev_we, dev_addr, dev_wdata
  );
endinterface

// File: rtl/io_bus_sequencer.sv
// ---------------------------------------------------------------------------
// io_bus_sequencer
// Purpose : turns the single-cycle core's IORead/IOWrite strobes for the
//           window 0xFFFFF800-0xFFFFFBFF into a multi-cycle one-hot
//           select/ack access to one of four slow peripherals, stalling the
//           core until the device acks or the access times out.
// Ports   : clk  - system clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - io_bus_sequencer_if.master (core strobes, stall, rdata,
//                  err, and the device select/ack bus)
// Params  : TIMEOUT   - BUSY cycles allowed without ack (1..255)
//           ERR_RDATA - read data returned on an aborted or illegal read
// ---------------------------------------------------------------------------
module io_bus_sequencer #(
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  io_bus_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [3:0]  r_sel;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_idx;
  logic [7:0]  r_cnt;

  logic        w_strobe;
  logic        w_legal;
  logic [3:0]  w_onehot;
  logic        w_ack;
  logic [31:0] w_slice;

  assign w_strobe = bus.io_read | bus.io_write;
  // Exactly one strobe and the address inside the 1 KiB IO window.
  assign w_legal  = (bus.io_read ^ bus.io_write) &&
                    (bus.addr[31:10] == 22'b1111_1111_1111_1111_1111_10);
  assign w_onehot = 4'b0001 << bus.addr[9:8];
  // r_sel is one-hot, so masking leaves only the selected device's ack.
  assign w_ack    = |(bus.dev_ack & r_sel);
  assign w_slice  = bus.dev_rdata[{r_idx, 5'b00000} +: 32];

  assign bus.stall     = ((r_state == S_IDLE) && w_strobe) || (r_state == S_BUSY);
  assign bus.rdata     = r_rdata;
  assign bus.err       = r_err;
  assign bus.dev_sel   = r_sel;
  assign bus.dev_we    = r_we;
  assign bus.dev_addr  = r_addr;
  assign bus.dev_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_sel   <= 4'b0000;
      r_we    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 32'h0;
      r_idx   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      // err is only ever set on the transition into DONE, so it lasts one cycle.
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            if (w_legal) begin
              r_sel   <= w_onehot;
              r_we    <= bus.io_write;
              r_addr  <= bus.addr[7:0];
              r_wdata <= bus.wdata;
              r_idx   <= bus.addr[9:8];
              r_cnt   <= 8'd0;
              r_state <= S_BUSY;
            end else begin
              r_err   <= 1'b1;
              if (bus.io_read) r_rdata <= ERR_RDATA;
              r_state <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          // Ack is tested first so it wins over a timeout in the same cycle.
          if (w_ack) begin
            if (!r_we) r_rdata <= w_slice;
            r_sel   <= 4'b0000;
            r_state <= S_DONE;
          end else if (r_cnt == LP_LAST) begin
            if (!r_we) r_rdata <= ERR_RDATA;
            r_sel   <= 4'b0000;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          // Strobes seen here still belong to the retiring instruction.
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_sequencer.sv
module tb_io_bus_sequencer;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  io_bus_sequencer_if bus();

  io_bus_sequencer #(.TIMEOUT(8), .ERR_RDATA(ERRV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Advance to the middle of the next cycle; inputs are driven there.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.io_read = 0; bus.io_write = 0; bus.addr = 0; bus.wdata = 0;
    bus.dev_rdata = '0; bus.dev_ack = 0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.stall !== 1'b0 || bus.err !== 1'b0 || bus.dev_sel !== 4'b0 ||
        bus.dev_we !== 1'b0 || bus.dev_addr !== 8'h0 || bus.dev_wdata !== 32'h0 ||
        bus.rdata !== 32'h0) begin
      n_errs++;
      $display("FAIL reset: stall=%b err=%b sel=%b we=%b addr=%h wd=%h rd=%h required all zero",
               bus.stall, bus.err, bus.dev_sel, bus.dev_we, bus.dev_addr, bus.dev_wdata, bus.rdata);
    end
  endtask

  task automatic test_read_imm();
    cyc();
    bus.io_read = 1; bus.addr = 32'hFFFF_F904; bus.dev_rdata[63:32] = 32'h0000_00A5;
    #1; n_checks++;
    if (bus.stall !== 1'b1 || bus.dev_sel !== 4'b0) begin
      n_errs++; $display("FAIL rd_imm_c0: stall=%b sel=%b required 1/0000", bus.stall, bus.dev_sel);
    end
    cyc(); bus.dev_ack = 4'b0010;
    #1; n_checks++;
    if (bus.stall !== 1'b1 || bus.dev_sel !== 4'b0010 || bus.dev_addr !== 8'h04 || bus.dev_we !== 1'b0) begin
      n_errs++; $display("FAIL rd_imm_c1: stall=%b sel=%b addr=%h we=%b required 1/0010/04/0",
                         bus.stall, bus.dev_sel, bus.dev_addr, bus.dev_we);
    end
    cyc(); bus.dev_ack = 0;
    #1; n_checks++;
    if (bus.stall !== 1'b0 || bus.rdata !== 32'hA5 || bus.err !== 1'b0 || bus.dev_sel !== 4'b0) begin
      n_errs++; $display("FAIL rd_imm_done: stall=%b rdata=%h err=%b sel=%b required 0/a5/0/0000",
                         bus.stall, bus.rdata, bus.err, bus.dev_sel);
    end
    cyc(); bus.io_read = 0;
    #1; n_checks++;
    if (bus.stall !== 1'b0 || bus.dev_sel !== 4'b0) begin
      n_errs++; $display("FAIL rd_imm_idle: stall=%b sel=%b required 0/0000", bus.stall, bus.dev_sel);
    end
  endtask

  task automatic test_write_delayed();
    int bad = 0;
    cyc();
    bus.io_write = 1; bus.addr = 32'hFFFF_FA10; bus.wdata = 32'h1234_5678;
    bus.dev_rdata[95:64] = 32'h0000_BBBB;
    #1; n_checks++;
    if (bus.stall !== 1'b1) begin
      n_errs++; $display("FAIL wr_c0_stall: stall=%b required 1", bus.stall);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      bus.wdata = 32'h0;  // latched copy must not follow the core
      bus.dev_ack = (i == 5) ? 4'b0100 : 4'b0000;
      #1;
      if (bus.stall !== 1'b1 || bus.dev_sel !== 4'b0100 || bus.dev_we !== 1'b1 ||
          bus.dev_wdata !== 32'h1234_5678 || bus.dev_addr !== 8'h10) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errs++; $display("FAIL wr_busy: %0d of 5 BUSY cycles wrong, required sel=0100 we=1 wd=12345678 stall=1", bad);
    end
    cyc(); bus.dev_ack = 0;
    #1; n_checks++;
    if (bus.stall !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'hA5 || bus.dev_sel !== 4'b0) begin
      n_errs++; $display("FAIL wr_done: stall=%b err=%b rdata=%h sel=%b required 0/0/a5/0000",
                         bus.stall, bus.err, bus.rdata, bus.dev_sel);
    end
    cyc(); bus.io_write = 0;
  endtask

  task automatic test_timeout(input bit late_ack);
    int bad = 0;
    cyc();
    bus.io_read = 1; bus.addr = 32'hFFFF_FB00; bus.dev_rdata[127:96] = 32'h3333_CAFE;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      bus.dev_ack = (late_ack && i == 8) ? 4'b1000 : 4'b0000;
      #1;
      if (bus.stall !== 1'b1 || bus.dev_sel !== 4'b1000 || bus.err !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errs++; $display("FAIL to_busy(ack=%0d): %0d of 8 BUSY cycles wrong", late_ack, bad);
    end
    cyc(); bus.dev_ack = 0;
    #1; n_checks++;
    if (late_ack) begin
      if (bus.stall !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h3333_CAFE || bus.dev_sel !== 4'b0) begin
        n_errs++; $display("FAIL to_lateack_done: stall=%b err=%b rdata=%h sel=%b required 0/0/3333cafe/0000",
                           bus.stall, bus.err, bus.rdata, bus.dev_sel);
      end
    end else begin
      if (bus.stall !== 1'b0 || bus.err !== 1'b1 || bus.rdata !== ERRV || bus.dev_sel !== 4'b0) begin
        n_errs++; $display("FAIL to_done: stall=%b err=%b rdata=%h sel=%b required 0/1/deadbeef/0000",
                           bus.stall, bus.err, bus.rdata, bus.dev_sel);
      end
    end
    cyc(); bus.io_read = 0;
    #1; n_checks++;
    if (bus.err !== 1'b0 || bus.stall !== 1'b0) begin
      n_errs++; $display("FAIL to_after(ack=%0d): err=%b stall=%b required 0/0", late_ack, bus.err, bus.stall);
    end
  endtask

  task automatic test_wrong_ack();
    int bad = 0;
    cyc();
    bus.io_read = 1; bus.addr = 32'hFFFF_F800; bus.dev_rdata[31:0] = 32'h0000_1111;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      bus.dev_ack = (i == 2) ? 4'b1110 : 4'b1000;
      #1;
      if (bus.stall !== 1'b1 || bus.dev_sel !== 4'b0001) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errs++; $display("FAIL wrong_ack: %0d of 3 cycles left BUSY, required stay BUSY sel=0001", bad);
    end
    cyc(); bus.dev_ack = 4'b0001;
    cyc(); bus.dev_ack = 0;
    #1; n_checks++;
    if (bus.stall !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'h0000_1111) begin
      n_errs++; $display("FAIL wrong_ack_done: stall=%b err=%b rdata=%h required 0/0/00001111",
                         bus.stall, bus.err, bus.rdata);
    end
    cyc(); bus.io_read = 0;
  endtask

  task automatic test_illegal(input bit both);
    cyc();
    if (both) begin
      bus.io_read = 1; bus.io_write = 1; bus.addr = 32'hFFFF_F800;
    end else begin
      bus.io_read = 1; bus.addr = 32'h0000_1000;
    end
    #1; n_checks++;
    if (bus.stall !== 1'b1 || bus.dev_sel !== 4'b0) begin
      n_errs++; $display("FAIL ill_c0(both=%0d): stall=%b sel=%b required 1/0000", both, bus.stall, bus.dev_sel);
    end
    cyc();
    #1; n_checks++;
    if (bus.stall !== 1'b0 || bus.err !== 1'b1 || bus.dev_sel !== 4'b0 ||
        (!both && bus.rdata !== ERRV)) begin
      n_errs++; $display("FAIL ill_done(both=%0d): stall=%b err=%b sel=%b rdata=%h required 0/1/0000 (rdata deadbeef on read)",
                         both, bus.stall, bus.err, bus.dev_sel, bus.rdata);
    end
    cyc(); bus.io_read = 0; bus.io_write = 0;
    #1; n_checks++;
    if (bus.err !== 1'b0 || bus.dev_sel !== 4'b0) begin
      n_errs++; $display("FAIL ill_after(both=%0d): err=%b sel=%b required 0/0000", both, bus.err, bus.dev_sel);
    end
  endtask

  task automatic test_reset_mid();
    cyc();
    bus.io_read = 1; bus.addr = 32'hFFFF_FA00; bus.dev_rdata[95:64] = 32'h5555_0000;
    cyc(); cyc();
    cyc(); rst = 1; bus.io_read = 0;   // 3rd BUSY cycle
    cyc(); rst = 0;
    #1; n_checks++;
    if (bus.stall !== 1'b0 || bus.dev_sel !== 4'b0 || bus.rdata !== 32'h0 || bus.err !== 1'b0) begin
      n_errs++; $display("FAIL rst_mid: stall=%b sel=%b rdata=%h err=%b required 0/0000/0/0",
                         bus.stall, bus.dev_sel, bus.rdata, bus.err);
    end
    cyc(); bus.dev_ack = 4'b0100;
    cyc(); bus.dev_ack = 0;
    #1; n_checks++;
    if (bus.stall !== 1'b0 || bus.dev_sel !== 4'b0 || bus.rdata !== 32'h0 || bus.err !== 1'b0) begin
      n_errs++; $display("FAIL rst_late_ack: stall=%b sel=%b rdata=%h err=%b required 0/0000/0/0",
                         bus.stall, bus.dev_sel, bus.rdata, bus.err);
    end
  endtask

  task automatic test_back_to_back();
    int sel_cycles = 0;
    cyc();
    bus.io_write = 1; bus.addr = 32'hFFFF_F800; bus.wdata = 32'hAAAA_5555;
    bus.dev_rdata[63:32] = 32'h0BAD_F00D;
    #1; if (bus.dev_sel != 0) sel_cycles++;
    cyc(); bus.dev_ack = 4'b0001;
    #1; if (bus.dev_sel != 0) sel_cycles++;
    n_checks++;
    if (bus.dev_sel !== 4'b0001 || bus.dev_we !== 1'b1 || bus.dev_wdata !== 32'hAAAA_5555) begin
      n_errs++; $display("FAIL b2b_wr: sel=%b we=%b wd=%h required 0001/1/aaaa5555", bus.dev_sel, bus.dev_we, bus.dev_wdata);
    end
    cyc(); bus.dev_ack = 0;   // DONE: write strobe still high, must be ignored
    #1; if (bus.dev_sel != 0) sel_cycles++;
    n_checks++;
    if (bus.stall !== 1'b0) begin
      n_errs++; $display("FAIL b2b_wr_done: stall=%b required 0", bus.stall);
    end
    cyc(); bus.io_write = 0; bus.io_read = 1; bus.addr = 32'hFFFF_F908;
    #1; if (bus.dev_sel != 0) sel_cycles++;
    n_checks++;
    if (bus.dev_sel !== 4'b0 || bus.stall !== 1'b1) begin
      n_errs++; $display("FAIL b2b_idle_gap: sel=%b stall=%b required 0000/1", bus.dev_sel, bus.stall);
    end
    cyc(); bus.dev_ack = 4'b0010;
    #1; if (bus.dev_sel != 0) sel_cycles++;
    n_checks++;
    if (bus.dev_sel !== 4'b0010 || bus.dev_we !== 1'b0 || bus.dev_addr !== 8'h08) begin
      n_errs++; $display("FAIL b2b_rd: sel=%b we=%b addr=%h required 0010/0/08", bus.dev_sel, bus.dev_we, bus.dev_addr);
    end
    cyc(); bus.dev_ack = 0;
    #1; if (bus.dev_sel != 0) sel_cycles++;
    n_checks++;
    if (bus.rdata !== 32'h0BAD_F00D || bus.err !== 1'b0 || bus.stall !== 1'b0) begin
      n_errs++; $display("FAIL b2b_rd_done: rdata=%h err=%b stall=%b required 0badf00d/0/0", bus.rdata, bus.err, bus.stall);
    end
    cyc(); bus.io_read = 0;
    #1; if (bus.dev_sel != 0) sel_cycles++;
    n_checks++;
    if (sel_cycles != 2) begin
      n_errs++; $display("FAIL b2b_sel_count: dev_sel active %0d cycles, required 2", sel_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_read_imm();
    test_write_delayed();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_wrong_ack();
    test_illegal(1'b0);
    test_illegal(1'b1);
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
